// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: FSM states, transfer sizes and requester IDs shared by the arbiter.
package mem_port_arbiter_pkg;
    typedef enum logic [2:0] {IDLE, REQ_I, REQ_D, WAIT_I, WAIT_D} state_t;
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;
    localparam logic REQ_ID_I = 1'b0;
    localparam logic REQ_ID_D = 1'b1;
endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// mem_port_arbiter_arb_pick: grant selector; ARB_ROUND_ROBIN_EN adds a last-grant pointer,
// otherwise data has fixed priority over fetch.
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
    input  logic clk,
    input  logic rst,
    input  logic issue,
`endif
    input  logic if_elig,
    input  logic d_elig,
    output logic grant_valid,
    output logic grant_id
);
    assign grant_valid = if_elig | d_elig;
`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
    always_comb begin
        last_d = issue ? grant_id : last_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_q <= REQ_ID_I;
        else     last_q <= last_d;
    end
    // on a tie the requester not granted last wins
    assign grant_id = (if_elig & d_elig) ? ~last_q : (d_elig ? REQ_ID_D : REQ_ID_I);
`else
    assign grant_id = d_elig ? REQ_ID_D : REQ_ID_I;
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between fetch and data, one transaction in flight.
// Arbitration policy: round-robin when ARB_ROUND_ROBIN_EN is defined, else data-first.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              IF_REQ,
    input  logic [ADDR_W-1:0] IF_ADDR,
    input  logic              IF_KILL,
    output logic              IF_ACK,
    output logic [31:0]       IF_RDATA,
    output logic              IF_ERR,
    output logic              IF_STALL,
    input  logic              D_REQ,
    input  logic              D_WE,
    input  logic [1:0]        D_SIZE,
    input  logic [ADDR_W-1:0] D_ADDR,
    input  logic [DATA_W-1:0] D_WDATA,
    output logic              D_ACK,
    output logic [DATA_W-1:0] D_RDATA,
    output logic              D_ERR,
    output logic              D_STALL,
    output logic              M_REQ,
    output logic              M_WE,
    output logic [1:0]        M_SIZE,
    output logic [ADDR_W-1:0] M_ADDR,
    output logic [DATA_W-1:0] M_WDATA,
    input  logic              M_GNT,
    input  logic              M_RVALID,
    input  logic [DATA_W-1:0] M_RDATA,
    input  logic              M_ERR
);
    state_t state_q, state_d;
    logic m_req_q, m_req_d, m_we_q, m_we_d;
    logic [1:0] m_size_q, m_size_d;
    logic [ADDR_W-1:0] m_addr_q, m_addr_d;
    logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
    logic if_ack_q, if_ack_d, if_err_q, if_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic drop_q, drop_d;
    logic if_elig, d_elig, grant_valid, grant_id, kill;

    // a requester being acked this cycle is not re-granted until it re-asserts
    assign if_elig = IF_REQ & ~if_ack_q;
    assign d_elig  = D_REQ & ~d_ack_q;
    assign kill    = drop_q | IF_KILL;

    mem_port_arbiter_arb_pick u_arb_pick (
`ifdef ARB_ROUND_ROBIN_EN
        .clk        (CLK),
        .rst        (RESET),
        .issue      (state_q == IDLE && grant_valid),
`endif
        .if_elig    (if_elig),
        .d_elig     (d_elig),
        .grant_valid(grant_valid),
        .grant_id   (grant_id)
    );

    always_comb begin
        state_d    = state_q;
        m_req_d    = m_req_q;
        m_we_d     = m_we_q;
        m_size_d   = m_size_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        if_ack_d   = 1'b0;
        if_err_d   = 1'b0;
        if_rdata_d = if_rdata_q;
        d_ack_d    = 1'b0;
        d_err_d    = 1'b0;
        d_rdata_d  = d_rdata_q;
        drop_d     = 1'b0;
        case (state_q)
            IDLE: if (grant_valid) begin
                m_req_d   = 1'b1;
                state_d   = (grant_id == REQ_ID_D) ? REQ_D : REQ_I;
                m_we_d    = (grant_id == REQ_ID_D) ? D_WE : 1'b0;
                m_size_d  = (grant_id == REQ_ID_D) ? D_SIZE : SIZE_W;
                m_addr_d  = (grant_id == REQ_ID_D) ? D_ADDR : IF_ADDR;
                m_wdata_d = (grant_id == REQ_ID_D) ? D_WDATA : '0;
            end
            REQ_I, REQ_D: begin
                drop_d = (state_q == REQ_I) & kill;
                if (M_GNT) begin
                    m_req_d = 1'b0;
                    state_d = (state_q == REQ_I) ? WAIT_I : WAIT_D;
                end
            end
            WAIT_I: if (M_RVALID) begin
                state_d    = IDLE;
                if_ack_d   = ~kill;
                if_err_d   = ~kill & M_ERR;
                if_rdata_d = m_addr_q[2] ? M_RDATA[63:32] : M_RDATA[31:0];
            end else begin
                drop_d = kill;
            end
            WAIT_D: if (M_RVALID) begin
                state_d   = IDLE;
                d_ack_d   = 1'b1;
                d_err_d   = M_ERR;
                d_rdata_d = M_RDATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= IDLE;
            m_req_q    <= 1'b0;
            m_we_q     <= 1'b0;
            m_size_q   <= '0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            if_ack_q   <= 1'b0;
            if_err_q   <= 1'b0;
            if_rdata_q <= '0;
            d_ack_q    <= 1'b0;
            d_err_q    <= 1'b0;
            d_rdata_q  <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            m_req_q    <= m_req_d;
            m_we_q     <= m_we_d;
            m_size_q   <= m_size_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            if_ack_q   <= if_ack_d;
            if_err_q   <= if_err_d;
            if_rdata_q <= if_rdata_d;
            d_ack_q    <= d_ack_d;
            d_err_q    <= d_err_d;
            d_rdata_q  <= d_rdata_d;
            drop_q     <= drop_d;
        end
    end

    assign IF_ACK   = if_ack_q;
    assign IF_ERR   = if_err_q;
    assign IF_RDATA = if_rdata_q;
    assign IF_STALL = IF_REQ & ~if_ack_q;
    assign D_ACK    = d_ack_q;
    assign D_ERR    = d_err_q;
    assign D_RDATA  = d_rdata_q;
    assign D_STALL  = D_REQ & ~d_ack_q;
    assign M_REQ    = m_req_q;
    assign M_WE     = m_we_q;
    assign M_SIZE   = m_size_q;
    assign M_ADDR   = m_addr_q;
    assign M_WDATA  = m_wdata_q;
endmodule
